// File: rtl/mem_sched_pkg.sv
// Shared definitions for the single-port memory scheduler: phase bit positions,
// FSM state encodings and the capture target of an outstanding access.
package mem_sched_pkg;

  localparam int unsigned ph_f = 0;
  localparam int unsigned ph_r = 1;
  localparam int unsigned ph_x = 2;
  localparam int unsigned ph_m = 3;
  localparam int unsigned ph_w = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CWAIT = 2'd1,
    S_LWAIT = 2'd2,
    S_LDONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    T_NONE = 2'd0,
    T_IF   = 2'd1,
    T_DM   = 2'd2,
    T_LD   = 2'd3
  } tgt_e;

endpackage

// File: rtl/mem_sched.sv
// Arbitrates the shared instruction/data memory port between fetch, load/store
// and the external loader, and holds the CPU phase while its access is pending.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int unsigned AW  = 16,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [4:0]    phase,
  input  logic          hlt,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_re,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);

  localparam int unsigned CW = $clog2(LAT + 1);

  state_e        r_state, w_state_nxt;
  tgt_e          r_tgt, w_tgt_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_if_rdata, r_dm_rdata, r_ld_rdata;

  logic          w_fetch, w_cpu_req, w_cpu_win, w_final;
  logic          w_mem_en, w_mem_we, w_ld_ack;
  logic          w_cap_if, w_cap_dm, w_cap_ld;
  logic          w_unused;

  assign w_unused  = ^{phase[ph_r], phase[ph_x], phase[ph_w]};
  assign w_fetch   = phase[ph_f];
  assign w_cpu_req = w_fetch | (phase[ph_m] & (dm_re | dm_we));
  assign w_cpu_win = w_cpu_req & ~(hlt & ld_req);
  assign w_final   = (r_cnt == CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_cnt_nxt   = r_cnt;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    mem_addr    = ld_addr;
    mem_wdata   = ld_wdata;
    w_ld_ack    = 1'b0;
    w_cap_if    = 1'b0;
    w_cap_dm    = 1'b0;
    w_cap_ld    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cpu_win) begin
          w_mem_en    = 1'b1;
          w_mem_we    = ~w_fetch & dm_we;
          mem_addr    = w_fetch ? if_addr : dm_addr;
          mem_wdata   = dm_wdata;
          w_cnt_nxt   = CW'(LAT);
          w_state_nxt = S_CWAIT;
          // The capture target is latched so it cannot depend on the held inputs.
          if (w_fetch)    w_tgt_nxt = T_IF;
          else if (dm_we) w_tgt_nxt = T_NONE;
          else            w_tgt_nxt = T_DM;
        end else if (ld_req) begin
          w_mem_en    = 1'b1;
          w_mem_we    = ld_we;
          w_cnt_nxt   = CW'(LAT);
          w_state_nxt = S_LWAIT;
          w_tgt_nxt   = ld_we ? T_NONE : T_LD;
        end
      end
      S_CWAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (w_final) begin
          w_cap_if    = (r_tgt == T_IF);
          w_cap_dm    = (r_tgt == T_DM);
          w_state_nxt = S_IDLE;
        end
      end
      S_LWAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (w_final) begin
          w_cap_ld    = (r_tgt == T_LD);
          w_state_nxt = S_LDONE;
        end
      end
      S_LDONE: begin
        w_ld_ack    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_tgt      <= T_NONE;
      r_cnt      <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_ld_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cap_if) r_if_rdata <= mem_rdata;
      if (w_cap_dm) r_dm_rdata <= mem_rdata;
      if (w_cap_ld) r_ld_rdata <= mem_rdata;
    end
  end

  // Gated by reset so the port and the phase generator see silence during reset.
  assign mem_en   = w_mem_en & n_rst;
  assign mem_we   = w_mem_we & n_rst;
  assign stall    = w_cpu_req & ~((r_state == S_CWAIT) & w_final) & n_rst;
  assign ld_ack   = w_ld_ack;
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;
  assign ld_rdata = r_ld_rdata;

endmodule

// File: tb/tb_mem_sched.sv
// Bench for mem_sched: directed scenarios, then a random CPU phase walk with a
// concurrent loader, checked against a transaction-level memory reference.
module tb_mem_sched;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 1;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [4:0]    phase;
  logic          hlt;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_re, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          ld_req, ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;
  logic [DW-1:0] ld_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          stall;

  mem_sched #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .n_rst(n_rst), .phase(phase), .hlt(hlt),
    .if_addr(if_addr), .if_rdata(if_rdata),
    .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 16) return 32'h8C22_0004;
    if (i == 32) return 32'hA5A5_0020;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Memory macro emulation: LAT-cycle read pipeline, garbage when not reading.
  logic [DW-1:0] ram   [0:1023];
  logic [DW-1:0] rpipe [0:LAT-1];
  logic          pre_done = 1'b0;
  assign mem_rdata = rpipe[LAT-1];

  always @(posedge clk) begin
    if (!pre_done) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
    end else if (mem_en && mem_we) begin
      ram[mem_addr[9:0]] <= mem_wdata;
    end
    rpipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[9:0]] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end

  logic [DW-1:0] ref_mem [0:1023];
  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Random-walk state
  int p, dur, ld_wait, op;
  bit ld_act, ld_rd, busy_prev, busy_entry, ack_prev, abort;
  logic [DW-1:0] m_if, m_dm;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    n_rst = 1'b0; phase = '0; hlt = 1'b0; if_addr = '0;
    dm_re = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    nxt();
    pre_done = 1'b1;
    smp();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ld_ack", ld_ack, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_ld_rdata", ld_rdata, 0);
    nxt();
    n_rst = 1'b1;

    // Fetch
    phase = 5'b00001; if_addr = 16'h0010;
    smp();
    chk("f_issue_en", mem_en, 1); chk("f_issue_addr", mem_addr, 16'h0010);
    chk("f_issue_we", mem_we, 0); chk("f_issue_stall", stall, 1);
    nxt(); smp();
    chk("f_wait_stall", stall, 0); chk("f_wait_en", mem_en, 0);
    nxt(); phase = 5'b00010;
    smp();
    chk("f_if_rdata", if_rdata, 32'h8C22_0004); chk("f_after_stall", stall, 0);
    nxt();

    // Store
    phase = 5'b01000; dm_we = 1'b1; dm_addr = 16'h0100; dm_wdata = 32'hDEAD_BEEF;
    ref_mem[10'h100] = 32'hDEAD_BEEF;
    smp();
    chk("st_en", mem_en, 1); chk("st_we", mem_we, 1); chk("st_addr", mem_addr, 16'h0100);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF); chk("st_stall", stall, 1);
    nxt(); smp();
    chk("st_wait_stall", stall, 0); chk("st_wait_en", mem_en, 0);
    nxt(); phase = 5'b10000; dm_we = 1'b0;
    smp();
    chk("st_dm_rdata_keep", dm_rdata, 0);
    nxt();

    // Load back
    phase = 5'b01000; dm_re = 1'b1;
    smp();
    chk("lw_en", mem_en, 1); chk("lw_we", mem_we, 0); chk("lw_stall", stall, 1);
    nxt(); smp();
    chk("lw_wait_stall", stall, 0);
    nxt(); phase = 5'b10000; dm_re = 1'b0;
    smp();
    chk("lw_dm_rdata", dm_rdata, ref_mem[10'h100]);
    chk("lw_if_keep", if_rdata, 32'h8C22_0004);
    nxt();

    // Loader write blocks a following fetch
    phase = 5'b00000; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0200;
    ld_wdata = 32'h1234_5678; ref_mem[10'h200] = 32'h1234_5678;
    smp();
    chk("lb_issue_en", mem_en, 1); chk("lb_issue_we", mem_we, 1);
    chk("lb_issue_addr", mem_addr, 16'h0200); chk("lb_issue_stall", stall, 0);
    nxt(); phase = 5'b00001; if_addr = 16'h0020;
    smp();
    chk("lb_lwait_stall", stall, 1); chk("lb_lwait_en", mem_en, 0);
    chk("lb_lwait_ack", ld_ack, 0);
    nxt(); smp();
    chk("lb_ack", ld_ack, 1); chk("lb_ldone_stall", stall, 1); chk("lb_ldone_en", mem_en, 0);
    nxt(); ld_req = 1'b0; ld_we = 1'b0;
    smp();
    chk("lb_cpu_en", mem_en, 1); chk("lb_cpu_addr", mem_addr, 16'h0020);
    chk("lb_cpu_stall", stall, 1); chk("lb_ack_pulse", ld_ack, 0);
    nxt(); smp();
    chk("lb_cpu_final_stall", stall, 0);
    nxt(); phase = 5'b00010;
    smp();
    chk("lb_if_rdata", if_rdata, ref_mem[10'h020]);
    chk("lb_ram_written", ram[10'h200], 32'h1234_5678);
    nxt();

    // Simultaneous fetch and loader read, hlt=0: CPU first
    phase = 5'b00001; if_addr = 16'h0010; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0200;
    smp();
    chk("sim_cpu_en", mem_en, 1); chk("sim_cpu_addr", mem_addr, 16'h0010);
    chk("sim_cpu_stall", stall, 1);
    nxt(); smp();
    chk("sim_cwait_stall", stall, 0); chk("sim_cwait_ack", ld_ack, 0);
    nxt(); phase = 5'b00000;
    smp();
    chk("sim_ld_en", mem_en, 1); chk("sim_ld_addr", mem_addr, 16'h0200);
    chk("sim_ld_we", mem_we, 0);
    nxt(); smp();
    chk("sim_lwait_ack", ld_ack, 0);
    nxt(); smp();
    chk("sim_ack", ld_ack, 1); chk("sim_ld_rdata", ld_rdata, 32'h1234_5678);
    chk("sim_if_rdata", if_rdata, 32'h8C22_0004);
    nxt(); ld_req = 1'b0;
    smp();
    chk("sim_ack_pulse", ld_ack, 0);
    nxt();

    // hlt=1: loader wins over a pending fetch, fetch follows after LDONE
    hlt = 1'b1; phase = 5'b00001; if_addr = 16'h0020;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0010;
    smp();
    chk("hlt_ld_en", mem_en, 1); chk("hlt_ld_addr", mem_addr, 16'h0010);
    chk("hlt_ld_stall", stall, 1);
    nxt(); nxt(); smp();
    chk("hlt_ack", ld_ack, 1); chk("hlt_ld_rdata", ld_rdata, 32'h8C22_0004);
    nxt(); ld_req = 1'b0;
    smp();
    chk("hlt_cpu_en", mem_en, 1); chk("hlt_cpu_addr", mem_addr, 16'h0020);
    nxt(); smp();
    chk("hlt_cpu_final_stall", stall, 0);
    nxt(); phase = 5'b00000; hlt = 1'b0;
    smp();
    chk("hlt_if_rdata", if_rdata, 32'hA5A5_0020);
    nxt();

    // Reset in the middle of a fetch
    phase = 5'b00001; if_addr = 16'h0010;
    smp();
    chk("rmid_issue_en", mem_en, 1);
    nxt();
    n_rst = 1'b0;
    #1;
    chk("rmid_en", mem_en, 0); chk("rmid_stall", stall, 0);
    chk("rmid_if_rdata", if_rdata, 0); chk("rmid_dm_rdata", dm_rdata, 0);
    chk("rmid_ld_rdata", ld_rdata, 0); chk("rmid_ld_ack", ld_ack, 0);
    nxt(); n_rst = 1'b1;
    smp();
    chk("rmid_refetch_en", mem_en, 1); chk("rmid_refetch_addr", mem_addr, 16'h0010);
    chk("rmid_refetch_stall", stall, 1);
    nxt(); smp();
    chk("rmid_final_stall", stall, 0);
    nxt(); phase = 5'b00000;
    smp();
    chk("rmid_if_rdata2", if_rdata, 32'h8C22_0004);
    nxt();

    // Random phase walk with a concurrent loader
    m_if = 32'h8C22_0004; m_dm = 32'h0; // dm_rdata was cleared by the reset above
    p = 0; dur = 0; op = 0; ld_act = 0; ld_rd = 0; ld_wait = 0;
    busy_prev = 0; busy_entry = 0; ack_prev = 0; abort = 0;
    for (int cyc = 0; cyc < 3000 && !abort; cyc++) begin
      if (dur == 0) begin
        busy_entry = busy_prev;
        if (p == 0) if_addr = 16'($urandom_range(0, 63));
        if (p == 3) begin
          op = int'($urandom_range(0, 3));
          dm_addr = 16'h0100 + 16'($urandom_range(0, 63));
          dm_wdata = $urandom;
          if (op >= 2) ref_mem[dm_addr[9:0]] = dm_wdata;
        end
      end
      phase = 5'(5'b00001 << p);
      dm_re = (p == 3) && (op == 1 || op == 3);
      dm_we = (p == 3) && (op >= 2);
      if (!ld_act && $urandom_range(0, 5) == 0) begin
        ld_act = 1; ld_wait = 0;
        ld_we = 1'($urandom_range(0, 1)); ld_rd = !ld_we;
        ld_addr = 16'h0200 + 16'($urandom_range(0, 63));
        ld_wdata = $urandom;
        if (ld_we) ref_mem[ld_addr[9:0]] = ld_wdata;
      end
      ld_req = ld_act;
      smp();
      dur++;
      chk("rnd_if_rdata", if_rdata, m_if);
      chk("rnd_dm_rdata", dm_rdata, m_dm);
      busy_prev = ld_req && !ld_ack;
      if (ld_ack) begin
        chk("rnd_ack_pulse", 32'(ld_act && !ack_prev), 1);
        if (ld_rd) chk("rnd_ld_rdata", ld_rdata, ref_mem[ld_addr[9:0]]);
        ld_act = 0;
      end else if (ld_act) begin
        ld_wait++;
        if (ld_wait > int'(4 * LAT + 12)) begin
          chk("rnd_ld_timeout", 32'(ld_wait), 0);
          abort = 1;
        end
      end
      ack_prev = ld_ack;
      if (!stall) begin
        if (!(p == 0 || (p == 3 && op != 0))) chk("rnd_dur_plain", 32'(dur), 1);
        else if (!busy_entry) chk("rnd_dur_mem", 32'(dur), LAT + 1);
        else chk("rnd_dur_blocked", 32'(dur >= int'(LAT + 1) && dur <= int'(2 * LAT + 3)), 1);
        if (p == 0) m_if = ref_mem[if_addr[9:0]];
        if (p == 3 && op == 1) m_dm = ref_mem[dm_addr[9:0]];
        p = (p + 1) % 5;
        dur = 0;
      end else if (dur > int'(2 * LAT + 4)) begin
        chk("rnd_phase_timeout", 32'(dur), 0);
        abort = 1;
      end
      nxt();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
